// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: CRC-8 constants and byte step (also used on the write path),
// plus the frame-reader state encoding.
package onewire_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLOT,
        ST_REC,
        ST_BYTE,
        ST_DONE
    } rd_state_e;

    // MSB-first shift; a received byte followed by its own CRC leaves a remainder of zero
    function automatic logic [7:0] crc8_byte_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] x;
        x = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ CRC8_POLY) : (x << 1);
        end
        return x;
    endfunction

endpackage

// File: rtl/onewire_frame_reader_if.sv
// Control/stream bundle of the 1-Wire frame reader. The slave modport is the reader itself;
// the master modport is whatever issues start and presents the bus level.
interface onewire_frame_reader_if;
    logic       start;
    logic       ow_in;
    logic       ow_drive_low;
    logic       busy;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic [7:0] crc_out;
    logic       crc_ok;
    logic       done;

    modport master (
        output start, ow_in,
        input  ow_drive_low, busy, byte_data, byte_valid, crc_out, crc_ok, done
    );

    modport slave (
        input  start, ow_in,
        output ow_drive_low, busy, byte_data, byte_valid, crc_out, crc_ok, done
    );
endinterface

// File: rtl/onewire_read_slot.sv
// One 1-Wire read time slot plus recovery: drive-low window, bit sampling, end-of-bit strobe.
// OW_READ_MAJORITY_EN selects a 2-of-3 majority around T_SAMPLE instead of a single sample.
module onewire_read_slot #(
    parameter int T_LOW    = 100,
    parameter int T_SAMPLE = 600,
    parameter int T_SLOT   = 3000,
    parameter int T_REC    = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic ow_in,
    output logic drive_low,
    output logic slot_end,
    output logic bit_value,
    output logic bit_valid
);
    localparam int T_TOTAL = T_SLOT + T_REC;
    localparam int CW      = $clog2(T_TOTAL);

    localparam logic [CW-1:0] CNT_LOW       = CW'(T_LOW);
    localparam logic [CW-1:0] CNT_SAMPLE    = CW'(T_SAMPLE);
    localparam logic [CW-1:0] CNT_SLOT_LAST = CW'(T_SLOT - 1);
    localparam logic [CW-1:0] CNT_LAST      = CW'(T_TOTAL - 1);

    logic          active;
    logic [CW-1:0] cnt;

    // go in the final recovery cycle restarts with no idle gap between bits
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (go) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            if (cnt == CNT_LAST) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign drive_low = active && (cnt < CNT_LOW);
    assign slot_end  = active && (cnt == CNT_SLOT_LAST);
    assign bit_valid = active && (cnt == CNT_LAST);

`ifdef OW_READ_MAJORITY_EN
    logic [1:0] early;

    always_ff @(posedge clk) begin
        if (rst) begin
            early     <= '0;
            bit_value <= 1'b0;
        end else if (active) begin
            if (cnt == CNT_SAMPLE - 1'b1) early[0] <= ow_in;
            if (cnt == CNT_SAMPLE)        early[1] <= ow_in;
            if (cnt == CNT_SAMPLE + 1'b1)
                bit_value <= (early[0] & early[1]) | (early[0] & ow_in) | (early[1] & ow_in);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_value <= 1'b0;
        end else if (active && (cnt == CNT_SAMPLE)) begin
            bit_value <= ow_in;
        end
    end
`endif

endmodule

// File: rtl/onewire_frame_reader.sv
// 1-Wire frame reader: PAYLOAD_BYTES data bytes plus a trailing CRC-8 byte, LSB-first.
// Sampling mode is chosen in onewire_read_slot by OW_READ_MAJORITY_EN.
//
// state | meaning
// IDLE  | waiting for start
// SLOT  | read slot in progress (drive low, then sample)
// REC   | bus released between slots
// BYTE  | fold assembled byte into CRC, emit payload byte
// DONE  | frame complete, crc_ok settled
module onewire_frame_reader #(
    parameter int PAYLOAD_BYTES = 8,
    parameter int T_LOW         = 100,
    parameter int T_SAMPLE      = 600,
    parameter int T_SLOT        = 3000,
    parameter int T_REC         = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    onewire_frame_reader_if.slave  bus
);
    import onewire_pkg::*;

    localparam int BW = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(PAYLOAD_BYTES);

    rd_state_e       state, state_next;
    logic            go, slot_end, bit_value, bit_valid, drive_low;
    logic [2:0]      bit_idx;
    logic [BW-1:0]   byte_idx;
    logic [7:0]      shreg, crc, crc_next, byte_data;
    logic            byte_valid, crc_ok;

    onewire_read_slot #(
        .T_LOW    (T_LOW),
        .T_SAMPLE (T_SAMPLE),
        .T_SLOT   (T_SLOT),
        .T_REC    (T_REC)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .ow_in     (bus.ow_in),
        .drive_low (drive_low),
        .slot_end  (slot_end),
        .bit_value (bit_value),
        .bit_valid (bit_valid)
    );

    assign crc_next = crc8_byte_step(crc, shreg);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_SLOT;
            ST_SLOT: if (slot_end)  state_next = ST_REC;
            ST_REC:  if (bit_valid) state_next = (bit_idx == 3'd7) ? ST_BYTE : ST_SLOT;
            ST_BYTE: state_next = (byte_idx == LAST_BYTE) ? ST_DONE : ST_SLOT;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        go = 1'b0;
        case (state)
            ST_IDLE: go = bus.start;
            ST_REC:  go = bit_valid && (bit_idx != 3'd7);
            ST_BYTE: go = (byte_idx != LAST_BYTE);
            default: go = 1'b0;
        endcase
        bus.busy         = (state != ST_IDLE);
        bus.done         = (state == ST_DONE);
        bus.ow_drive_low = drive_low;
        bus.byte_data    = byte_data;
        bus.byte_valid   = byte_valid;
        bus.crc_out      = crc;
        bus.crc_ok       = crc_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx    <= '0;
            byte_idx   <= '0;
            shreg      <= '0;
            crc        <= CRC8_INIT;
            crc_ok     <= 1'b0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (state)
                ST_IDLE: if (bus.start) begin
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    crc      <= CRC8_INIT;
                    crc_ok   <= 1'b0;
                end
                ST_REC: if (bit_valid) begin
                    shreg[bit_idx] <= bit_value;
                    bit_idx        <= bit_idx + 1'b1;
                end
                ST_BYTE: begin
                    crc <= crc_next;
                    if (byte_idx != LAST_BYTE) begin
                        byte_data  <= shreg;
                        byte_valid <= 1'b1;
                        byte_idx   <= byte_idx + 1'b1;
                    end else begin
                        crc_ok <= (crc_next == 8'h00);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_frame_reader.sv
// Directed bench for onewire_frame_reader with a small open-drain slave model.
// Expected glitch behaviour follows OW_READ_MAJORITY_EN.
module tb_onewire_frame_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    onewire_frame_reader_if bus();

    onewire_frame_reader #(
        .PAYLOAD_BYTES (1),
        .T_LOW         (2),
        .T_SAMPLE      (5),
        .T_SLOT        (12),
        .T_REC         (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] tx_bits = 16'hFFFF;
    int slot_no = -1;
    int sl_cnt = 0;
    int glitch_slot = -1;
    logic drive_prev = 1'b0;

    int bv_cnt, done_cnt, busy_cyc, drive_cyc, slot_cnt;
    logic [7:0] last_byte, crc_at_bv, crc_at_done;

    // Slave model: bus reads low while the master drives, otherwise the current bit
    always @(negedge clk) begin
        if (bus.ow_drive_low && !drive_prev) begin
            slot_no++;
            slot_cnt++;
            sl_cnt = 0;
        end else begin
            sl_cnt++;
        end
        drive_prev = bus.ow_drive_low;
        if (bus.ow_drive_low) drive_cyc++;
        if (bus.busy) busy_cyc++;
        if (bus.byte_valid) begin
            bv_cnt++;
            last_byte = bus.byte_data;
            crc_at_bv = bus.crc_out;
        end
        if (bus.done) begin
            done_cnt++;
            crc_at_done = bus.crc_out;
        end
        if (bus.ow_drive_low)
            bus.ow_in = 1'b0;
        else if (slot_no < 0 || slot_no > 15)
            bus.ow_in = 1'b1;
        else if (slot_no == glitch_slot && sl_cnt == 5)
            bus.ow_in = 1'b0;
        else
            bus.ow_in = tx_bits[slot_no[3:0]];
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input int glitch);
        tx_bits     = {b1, b0};
        slot_no     = -1;
        glitch_slot = glitch;
        bv_cnt = 0; done_cnt = 0; busy_cyc = 0; drive_cyc = 0; slot_cnt = 0;
        last_byte = 8'h00; crc_at_bv = 8'h00; crc_at_done = 8'h00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input logic start_in_done);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(bus.done), 32'h1);
        if (start_in_done) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_drive", 32'(bus.ow_drive_low), 32'h0);
        chk("rst_busy",  32'(bus.busy),         32'h0);
        chk("rst_bv",    32'(bus.byte_valid),   32'h0);
        chk("rst_data",  32'(bus.byte_data),    32'h0);
        chk("rst_crc",   32'(bus.crc_out),      32'h0);
        chk("rst_ok",    32'(bus.crc_ok),       32'h0);
        chk("rst_done",  32'(bus.done),         32'h0);
        rst = 1'b0;
        tick();

        // 0x01 then its CRC 0x07
        run_frame(8'h01, 8'h07, -1);
        wait_done(400, 1'b0);
        repeat (3) tick();
        chk("f1_bv_cnt",   32'(bv_cnt),      32'd1);
        chk("f1_byte",     32'(last_byte),   32'h01);
        chk("f1_crc_b0",   32'(crc_at_bv),   32'h07);
        chk("f1_crc_end",  32'(crc_at_done), 32'h00);
        chk("f1_done_cnt", 32'(done_cnt),    32'd1);
        chk("f1_crc_ok",   32'(bus.crc_ok),  32'h1);
        chk("f1_busy_cyc", 32'(busy_cyc),    32'd227);
        chk("f1_slots",    32'(slot_cnt),    32'd16);
        chk("f1_drive",    32'(drive_cyc),   32'd32);
        chk("f1_idle",     32'(bus.busy),    32'h0);

        // 0xFF then its CRC 0xF3
        run_frame(8'hFF, 8'hF3, -1);
        wait_done(400, 1'b0);
        repeat (3) tick();
        chk("f2_byte",   32'(last_byte),   32'hFF);
        chk("f2_crc_b0", 32'(crc_at_bv),   32'hF3);
        chk("f2_crc_ok", 32'(bus.crc_ok),  32'h1);

        // corrupted CRC byte: remainder 0xF3^0xF2=0x01 stepped -> 0x07
        run_frame(8'hFF, 8'hF2, -1);
        wait_done(400, 1'b0);
        repeat (3) tick();
        chk("f3_crc_end", 32'(crc_at_done), 32'h07);
        chk("f3_crc_ok",  32'(bus.crc_ok),  32'h0);
        chk("f3_bv_cnt",  32'(bv_cnt),      32'd1);

        // start mid-frame and during DONE must both be ignored
        run_frame(8'h01, 8'h07, -1);
        repeat (50) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(400, 1'b1);
        repeat (300) tick();
        chk("f4_done_cnt", 32'(done_cnt), 32'd1);
        chk("f4_busy_cyc", 32'(busy_cyc), 32'd227);
        chk("f4_bv_cnt",   32'(bv_cnt),   32'd1);
        chk("f4_idle",     32'(bus.busy), 32'h0);

        // reset at slot count 1
        run_frame(8'h01, 8'h07, -1);
        chk("f5_slot_c0", 32'(bus.ow_drive_low), 32'h1);
        tick();
        chk("f5_slot_c1", 32'(bus.ow_drive_low), 32'h1);
        rst = 1'b1;
        tick();
        chk("f5_rst_drive", 32'(bus.ow_drive_low), 32'h0);
        chk("f5_rst_busy",  32'(bus.busy),         32'h0);
        rst = 1'b0;
        repeat (300) tick();
        chk("f5_no_done", 32'(done_cnt), 32'd0);
        chk("f5_no_bv",   32'(bv_cnt),   32'd0);

        // one-cycle low glitch at sample point of bit 0 (a '1')
        run_frame(8'hFF, 8'hF3, 0);
        wait_done(400, 1'b0);
        repeat (3) tick();
`ifdef OW_READ_MAJORITY_EN
        chk("f6_glitch_byte", 32'(last_byte),  32'hFF);
        chk("f6_glitch_ok",   32'(bus.crc_ok), 32'h1);
`else
        chk("f6_glitch_byte", 32'(last_byte),  32'hFE);
        chk("f6_glitch_ok",   32'(bus.crc_ok), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
